// File: rtl/tdm_demux4.sv
// tdm_demux4 - four-channel time-division demultiplexer (receive side of a
// 4:1 TDM link). One interleaved sample stream (slot order a,b,c,d, marker on
// slot a) is steered into four registered channel outputs. A HUNT/LOCK sync
// machine finds frame alignment, holds it, and flags marker violations.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid        sample present on in_data this cycle
//   in_data         interleaved sample (WIDTH bits)
//   in_sof          slot-a marker, qualified by in_valid
//   out_a..out_d    last sample written to each channel, held until overwritten
//   out_valid       one-cycle write strobe per channel (bit0=a .. bit3=d)
//   frame_done      one-cycle pulse when slot d completes an aligned frame
//   sel             slot index expected for the next accepted sample
//   locked          high while in LOCK
//   sync_err        one-cycle pulse on a framing violation
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sof,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [3:0]       out_valid,
  output logic             frame_done,
  output logic [1:0]       sel,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sel_q, sel_d;
  logic [3:0][WIDTH-1:0]  ch_q, ch_d;
  logic [3:0]             vld_q, vld_d;
  logic                   fd_q, fd_d;
  logic                   se_q, se_d;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ch_d    = ch_q;
    vld_d   = 4'b0000;
    fd_d    = 1'b0;
    se_d    = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        // A marker always (re)starts a frame at slot a, whatever the state.
        // In LOCK it is only an error if it arrives before the frame ended.
        se_d     = (state_q == LOCK) && (sel_q != 2'd0);
        ch_d[0]  = in_data;
        vld_d    = 4'b0001;
        sel_d    = 2'd1;
        state_d  = LOCK;
      end else if (state_q == LOCK) begin
        if (sel_q == 2'd0) begin
          // Slot a without its marker: alignment lost, drop the sample.
          se_d    = 1'b1;
          sel_d   = 2'd0;
          state_d = HUNT;
        end else begin
          ch_d[sel_q]  = in_data;
          vld_d[sel_q] = 1'b1;
          fd_d         = (sel_q == 2'd3);
          sel_d        = sel_q + 2'd1;   // wraps 3 -> 0
        end
      end
      // HUNT without a marker: sample discarded silently.
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      sel_q   <= 2'd0;
      ch_q    <= '0;
      vld_q   <= 4'b0000;
      fd_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ch_q    <= ch_d;
      vld_q   <= vld_d;
      fd_q    <= fd_d;
      se_q    <= se_d;
    end
  end

  assign out_a      = ch_q[0];
  assign out_b      = ch_q[1];
  assign out_c      = ch_q[2];
  assign out_d      = ch_q[3];
  assign out_valid  = vld_q;
  assign frame_done = fd_q;
  assign sel        = sel_q;
  assign locked     = (state_q == LOCK);
  assign sync_err   = se_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4. Each step drives one input cycle and pushes
// the expected post-edge output image onto a scoreboard queue; after the edge
// the entry is popped and compared field by field.
module tb_tdm_demux4;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_sof;
  logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
  logic [3:0]       out_valid;
  logic             frame_done;
  logic [1:0]       sel;
  logic             locked;
  logic             sync_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]            vld;
    logic                  fd;
    logic                  se;
    logic [1:0]            sel;
    logic                  lk;
    logic [3:0][WIDTH-1:0] ch;
  } exp_t;

  exp_t                  exp_q[$];
  logic [3:0][WIDTH-1:0] exp_ch;

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_c      (out_c),
    .out_d      (out_d),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .sel        (sel),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".out_a"}, 32'(out_a), 0);
    chk({tag, ".out_b"}, 32'(out_b), 0);
    chk({tag, ".out_c"}, 32'(out_c), 0);
    chk({tag, ".out_d"}, 32'(out_d), 0);
    chk({tag, ".out_valid"}, 32'(out_valid), 0);
    chk({tag, ".frame_done"}, 32'(frame_done), 0);
    chk({tag, ".sync_err"}, 32'(sync_err), 0);
    chk({tag, ".sel"}, 32'(sel), 0);
    chk({tag, ".locked"}, 32'(locked), 0);
  endtask

  // Drive one cycle; ev is the expected strobe, which also names the channel
  // whose expected register takes this sample.
  task automatic step(input string tag, input logic v, input logic s,
                      input logic [WIDTH-1:0] d, input logic [3:0] ev,
                      input logic efd, input logic ese,
                      input logic [1:0] esel, input logic elk);
    exp_t e;
    exp_t g;
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    for (int i = 0; i < 4; i++) if (ev[i]) exp_ch[i] = d;
    e.vld = ev; e.fd = efd; e.se = ese; e.sel = esel; e.lk = elk; e.ch = exp_ch;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end else begin
      g = exp_q.pop_front();
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(g.vld));
      chk({tag, ".frame_done"}, 32'(frame_done), 32'(g.fd));
      chk({tag, ".sync_err"}, 32'(sync_err), 32'(g.se));
      chk({tag, ".sel"}, 32'(sel), 32'(g.sel));
      chk({tag, ".locked"}, 32'(locked), 32'(g.lk));
      chk({tag, ".out_a"}, 32'(out_a), 32'(g.ch[0]));
      chk({tag, ".out_b"}, 32'(out_b), 32'(g.ch[1]));
      chk({tag, ".out_c"}, 32'(out_c), 32'(g.ch[2]));
      chk({tag, ".out_d"}, 32'(out_d), 32'(g.ch[3]));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; exp_ch = '0;
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst = 1'b0;

    // HUNT: unmarked samples ignored, marker locks.
    step("hunt0", 1, 0, 8'hAA, 4'h0, 0, 0, 2'd0, 0);
    step("hunt1", 1, 0, 8'hBB, 4'h0, 0, 0, 2'd0, 0);
    step("hunt2", 1, 1, 8'h01, 4'h1, 0, 0, 2'd1, 1);
    step("hunt3", 1, 0, 8'h02, 4'h2, 0, 0, 2'd2, 1);
    step("hunt4", 1, 0, 8'h03, 4'h4, 0, 0, 2'd3, 1);
    step("hunt5", 1, 0, 8'h04, 4'h8, 1, 0, 2'd0, 1);

    // Back-to-back aligned frame.
    step("b2b0", 1, 1, 8'h11, 4'h1, 0, 0, 2'd1, 1);
    step("b2b1", 1, 0, 8'h22, 4'h2, 0, 0, 2'd2, 1);
    step("b2b2", 1, 0, 8'h33, 4'h4, 0, 0, 2'd3, 1);
    step("b2b3", 1, 0, 8'h44, 4'h8, 1, 0, 2'd0, 1);
    chk("b2b.regs", {out_a, out_b, out_c, out_d}, 32'h11223344);

    // Same frame with gaps; in_sof during a gap must be ignored.
    step("gap0", 1, 1, 8'h11, 4'h1, 0, 0, 2'd1, 1);
    step("gap1", 0, 1, 8'hEE, 4'h0, 0, 0, 2'd1, 1);
    step("gap2", 1, 0, 8'h22, 4'h2, 0, 0, 2'd2, 1);
    step("gap3", 0, 0, 8'hEE, 4'h0, 0, 0, 2'd2, 1);
    step("gap4", 0, 1, 8'hEE, 4'h0, 0, 0, 2'd2, 1);
    step("gap5", 1, 0, 8'h33, 4'h4, 0, 0, 2'd3, 1);
    step("gap6", 0, 0, 8'hEE, 4'h0, 0, 0, 2'd3, 1);
    step("gap7", 0, 0, 8'hEE, 4'h0, 0, 0, 2'd3, 1);
    step("gap8", 0, 1, 8'hEE, 4'h0, 0, 0, 2'd3, 1);
    step("gap9", 1, 0, 8'h44, 4'h8, 1, 0, 2'd0, 1);
    chk("gap.regs", {out_a, out_b, out_c, out_d}, 32'h11223344);

    // Early marker after slot b truncates the frame.
    step("early0", 1, 1, 8'h15, 4'h1, 0, 0, 2'd1, 1);
    step("early1", 1, 0, 8'h26, 4'h2, 0, 0, 2'd2, 1);
    step("early2", 1, 1, 8'h55, 4'h1, 0, 1, 2'd1, 1);
    step("early3", 1, 0, 8'h66, 4'h2, 0, 0, 2'd2, 1);
    step("early4", 1, 0, 8'h77, 4'h4, 0, 0, 2'd3, 1);
    step("early5", 1, 0, 8'h88, 4'h8, 1, 0, 2'd0, 1);
    chk("early.regs", {out_a, out_b, out_c, out_d}, 32'h55667788);

    // Missing marker at slot a drops lock without touching registers.
    step("miss0", 1, 0, 8'h99, 4'h0, 0, 1, 2'd0, 0);
    step("miss1", 0, 0, 8'h00, 4'h0, 0, 0, 2'd0, 0);
    step("miss2", 1, 0, 8'hAB, 4'h0, 0, 0, 2'd0, 0);
    chk("miss.regs", {out_a, out_b, out_c, out_d}, 32'h55667788);
    step("miss3", 1, 1, 8'h12, 4'h1, 0, 0, 2'd1, 1);
    step("miss4", 1, 0, 8'h34, 4'h2, 0, 0, 2'd2, 1);

    // Asynchronous reset between edges with sel=2.
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    exp_ch = '0;
    @(negedge clk); rst = 1'b0;
    step("post0", 1, 0, 8'h56, 4'h0, 0, 0, 2'd0, 0);
    step("post1", 1, 1, 8'h21, 4'h1, 0, 0, 2'd1, 1);
    step("post2", 1, 0, 8'h22, 4'h2, 0, 0, 2'd2, 1);
    step("post3", 1, 0, 8'h23, 4'h4, 0, 0, 2'd3, 1);
    step("post4", 1, 0, 8'h24, 4'h8, 1, 0, 2'd0, 1);
    step("idle", 0, 0, 8'h00, 4'h0, 0, 0, 2'd0, 1);

    chk("queue.drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
